// File: rtl/wb_sram_responder.sv
// Pipelined Wishbone B4 responder backed by a word RAM, with a higher-priority side port
// used to preload and dump memory. Responses leave through a fixed-latency shift line.
module wb_sram_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned LATENCY   = 0
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         wb_cyc,
  input  logic                         wb_stb,
  input  logic                         wb_we,
  input  logic [29:0]                  wb_addr,
  input  logic [3:0]                   wb_sel,
  input  logic [31:0]                  wb_mosi,
  output logic [31:0]                  wb_miso,
  output logic                         wb_ack,
  output logic                         wb_err,
  output logic                         wb_stall,
  input  logic                         dbg_req,
  input  logic                         dbg_we,
  input  logic [$clog2(MEM_WORDS)-1:0] dbg_addr,
  input  logic [31:0]                  dbg_wdata,
  output logic [31:0]                  dbg_rdata,
  output logic                         dbg_rvalid
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  if (LATENCY > 7) begin : g_bad_latency
    $error("wb_sram_responder: LATENCY must be in 0..7");
  end
  if (MEM_WORDS < 2 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_depth
    $error("wb_sram_responder: MEM_WORDS must be a power of 2, at least 2");
  end

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } resp_t;

  logic [31:0] mem [MEM_WORDS];

  logic          borrow;
  logic [31:0]   offset;
  logic          in_range;
  logic [AW-1:0] wb_idx;
  logic          accept;
  logic          wb_wr;
  logic          dbg_wr;
  logic          dbg_rd;

  resp_t new_resp;
  resp_t out_resp;
  resp_t pipe_d [LATENCY+1];
  resp_t pipe_q [LATENCY+1];

  logic [31:0] dbg_rdata_q;
  logic        dbg_rvalid_q;

  // A borrow out of the subtraction means the address lies below the window.
  always_comb begin
    {borrow, offset} = {3'b000, wb_addr} - {1'b0, BASE_ADDR};
    in_range         = ~borrow && (offset < MEM_WORDS);
    wb_idx           = offset[AW-1:0];
  end

  // The side port owns the RAM whenever it asks; the bus simply waits.
  assign accept = wb_cyc & wb_stb & ~dbg_req;
  assign wb_wr  = accept & wb_we & in_range;
  assign dbg_wr = dbg_req & dbg_we;
  assign dbg_rd = dbg_req & ~dbg_we;

  always_comb begin
    new_resp       = '0;
    new_resp.valid = accept;
    new_resp.err   = accept & ~in_range;
    if (accept && in_range && !wb_we) begin
      new_resp.data = mem[wb_idx];
    end
  end

  // Dropping wb_cyc flushes every response still travelling down the line.
  always_comb begin
    for (int unsigned i = 0; i <= LATENCY; i++) begin
      pipe_d[i] = '0;
    end
    if (wb_cyc) begin
      pipe_d[0] = new_resp;
      for (int unsigned i = 1; i <= LATENCY; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int unsigned i = 0; i <= LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i <= LATENCY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (dbg_wr) begin
      mem[dbg_addr] <= dbg_wdata;
    end else if (wb_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wb_sel[i]) begin
          mem[wb_idx][8*i +: 8] <= wb_mosi[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      dbg_rdata_q  <= '0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      dbg_rvalid_q <= dbg_rd;
      if (dbg_rd) begin
        dbg_rdata_q <= mem[dbg_addr];
      end
    end
  end

  // A response due in a cycle where wb_cyc is low is cancelled, not merely delayed.
  assign out_resp   = pipe_q[LATENCY];
  assign wb_ack     = out_resp.valid & ~out_resp.err & wb_cyc;
  assign wb_err     = out_resp.valid & out_resp.err & wb_cyc;
  assign wb_miso    = wb_ack ? out_resp.data : 32'h0;
  assign wb_stall   = dbg_req & i_reset_n;
  assign dbg_rdata  = dbg_rdata_q;
  assign dbg_rvalid = dbg_rvalid_q;

  a_ack_err_excl: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    !(wb_ack && wb_err));
  a_miso_idle: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    wb_ack || (wb_miso == 32'h0));

endmodule

// File: tb/tb_wb_sram_responder.sv
// Randomised scoreboard bench for wb_sram_responder: a word-array reference model predicts
// each bus response and side-port read; a negedge monitor pops and compares.
module tb_wb_sram_responder;

  localparam int unsigned MW   = 64;
  localparam int unsigned BASE = 8;
  localparam int unsigned LAT  = 3;
  localparam int unsigned AW   = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wb_cyc, wb_stb, wb_we;
  logic [29:0]   wb_addr;
  logic [3:0]    wb_sel;
  logic [31:0]   wb_mosi, wb_miso;
  logic          wb_ack, wb_err, wb_stall;
  logic          dbg_req, dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [31:0]   dbg_wdata, dbg_rdata;
  logic          dbg_rvalid;

  always #5 clk = ~clk;

  wb_sram_responder #(
    .MEM_WORDS(MW),
    .BASE_ADDR(BASE),
    .LATENCY  (LAT)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .wb_cyc    (wb_cyc),
    .wb_stb    (wb_stb),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_sel    (wb_sel),
    .wb_mosi   (wb_mosi),
    .wb_miso   (wb_miso),
    .wb_ack    (wb_ack),
    .wb_err    (wb_err),
    .wb_stall  (wb_stall),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_rdata (dbg_rdata),
    .dbg_rvalid(dbg_rvalid)
  );

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] ref_mem [MW];
  int          cycle = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        dexp_valid = 1'b0;
  logic [31:0] dexp_data = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference model: applies the acceptance rules to a plain word array.
  always @(posedge clk) begin
    exp_t        e;
    longint      a;
    int          idx;
    logic [31:0] m;
    cycle++;
    if (rst_n) begin
      dexp_valid = 1'b0;
      if (!wb_cyc) sbq.delete();
      if (dbg_req) begin
        if (dbg_we) ref_mem[dbg_addr] = dbg_wdata;
        else begin
          dexp_valid = 1'b1;
          dexp_data  = ref_mem[dbg_addr];
        end
      end else if (wb_cyc && wb_stb) begin
        a     = longint'(wb_addr);
        e.due = cycle + LAT;
        e.err = 1'b0;
        e.data = 32'h0;
        if (a < BASE || a >= BASE + MW) begin
          e.err = 1'b1;
        end else begin
          idx = int'(a - BASE);
          if (wb_we) begin
            m = {{8{wb_sel[3]}}, {8{wb_sel[2]}}, {8{wb_sel[1]}}, {8{wb_sel[0]}}};
            ref_mem[idx] = (ref_mem[idx] & ~m) | (wb_mosi & m);
          end else begin
            e.data = ref_mem[idx];
          end
        end
        sbq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check("reset_ack", wb_ack, 0);
      check("reset_err", wb_err, 0);
      check("reset_stall", wb_stall, 0);
      check("reset_miso", wb_miso, 0);
      check("reset_rvalid", dbg_rvalid, 0);
      check("reset_rdata", dbg_rdata, 0);
    end else begin
      check("stall", wb_stall, dbg_req);
      check("ack_err_excl", wb_ack & wb_err, 0);
      if (!wb_ack) check("miso_idle", wb_miso, 0);
      if (!wb_cyc) begin
        check("cyc_low_no_resp", wb_ack | wb_err, 0);
      end else if (wb_ack || wb_err) begin
        n_checks++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_resp: got ack=%b err=%b, expected none (cycle %0d)",
                   wb_ack, wb_err, cycle);
        end else begin
          e = sbq.pop_front();
          check("resp_cycle", cycle, e.due);
          check("resp_err", wb_err, e.err);
          check("resp_data", wb_miso, e.data);
        end
      end else if (sbq.size() > 0 && sbq[0].due <= cycle) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing_resp: got none, expected response due cycle %0d (cycle %0d)",
                 sbq[0].due, cycle);
        void'(sbq.pop_front());
      end
      check("dbg_rvalid", dbg_rvalid, dexp_valid);
      check("dbg_rdata", dbg_rdata, dexp_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input int n);
    wb_stb  = 1'b0;
    dbg_req = 1'b0;
    repeat (n) tick();
  endtask

  task automatic wb(input logic we, input int a, input logic [3:0] sel, input logic [31:0] d);
    wb_cyc  = 1'b1;
    wb_stb  = 1'b1;
    wb_we   = we;
    wb_addr = 30'(a);
    wb_sel  = sel;
    wb_mosi = d;
    dbg_req = 1'b0;
    tick();
  endtask

  task automatic dbg(input logic we, input int idx, input logic [31:0] d);
    wb_stb    = 1'b0;
    dbg_req   = 1'b1;
    dbg_we    = we;
    dbg_addr  = AW'(idx);
    dbg_wdata = d;
    tick();
    dbg_req = 1'b0;
  endtask

  initial begin
    int r;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_sel = '0; wb_mosi = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wb_cyc = 1'b1;

    for (int i = 0; i < int'(MW); i++) dbg(1'b1, i, $urandom);
    dbg(1'b1, 5, 32'hDEADBEEF);
    dbg(1'b1, 7, 32'h11223344);

    wb(1'b0, BASE + 5, 4'hF, 32'h0);
    nop(LAT + 2);

    for (int i = 0; i < 4; i++) wb(1'b1, BASE + i, 4'hF, $urandom);
    for (int i = 0; i < 4; i++) wb(1'b0, BASE + i, 4'hF, 32'h0);
    nop(LAT + 2);

    wb(1'b1, BASE + 7, 4'b0010, 32'hAABBCCDD);
    wb(1'b0, BASE + 7, 4'hF, 32'h0);
    nop(LAT + 2);

    wb(1'b1, BASE + MW, 4'hF, 32'hFFFFFFFF);
    wb(1'b1, BASE - 1, 4'hF, 32'hFFFFFFFF);
    wb(1'b0, 30'h3FFFFFFF, 4'hF, 32'h0);
    nop(LAT + 2);
    dbg(1'b0, 0, 32'h0);
    dbg(1'b0, MW - 1, 32'h0);
    nop(2);

    for (int i = 0; i < 3; i++) wb(1'b0, BASE + 5, 4'hF, 32'h0);
    wb_cyc = 1'b0;
    wb_stb = 1'b1;
    tick();
    wb(1'b0, BASE + 7, 4'hF, 32'h0);
    nop(LAT + 2);

    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 30'(BASE + 2); wb_sel = 4'hF;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = AW'(9);
    tick();
    dbg_req = 1'b0;
    tick();
    nop(LAT + 2);

    for (int n = 0; n < 800; n++) begin
      wb_cyc  = ($urandom_range(15) != 0);
      wb_stb  = ($urandom_range(3) != 0);
      wb_we   = $urandom_range(1) == 1;
      r       = $urandom_range(9);
      case (r)
        0:       wb_addr = 30'($urandom);
        1:       wb_addr = 30'(BASE + MW + $urandom_range(3));
        2:       wb_addr = 30'($urandom_range(BASE - 1));
        3, 4, 5: wb_addr = 30'(BASE + $urandom_range(7));
        default: wb_addr = 30'(BASE + $urandom_range(MW - 1));
      endcase
      wb_sel    = 4'($urandom);
      wb_mosi   = $urandom;
      dbg_req   = ($urandom_range(7) == 0);
      dbg_we    = $urandom_range(1) == 1;
      dbg_addr  = AW'($urandom_range(MW - 1));
      dbg_wdata = $urandom;
      tick();
    end
    wb_cyc = 1'b1;
    nop(LAT + 3);
    check("drain_random", sbq.size(), 0);

    for (int i = 0; i < 3; i++) wb(1'b0, BASE + i, 4'hF, 32'h0);
    #2 rst_n = 1'b0;
    dbg_req = 1'b1;
    dbg_we  = 1'b0;
    #1;
    check("async_reset_ack", wb_ack, 0);
    check("async_reset_err", wb_err, 0);
    check("async_reset_stall", wb_stall, 0);
    sbq.delete();
    dexp_valid = 1'b0;
    dexp_data  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    dbg_req = 1'b0;
    wb_stb  = 1'b0;
    rst_n   = 1'b1;
    nop(LAT + 4);
    wb(1'b0, BASE + 5, 4'hF, 32'h0);
    nop(LAT + 3);
    check("drain_after_reset", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
